// File: rtl/bf16_pkg.sv
// Shared fp32/bfloat16 constants and the status flag layout for the bf16 output path.
package bf16_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;

    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [15:0] BF16_POS_INF = 16'h7F80;
    localparam logic [FP32_EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic nan;
        logic overflow;
        logic inexact;
        logic zero;
    } bf16_flags_t;

endpackage

// File: rtl/bf16_out_fifo.sv
// Output FIFO for rounded results; no write-to-read bypass, so a push is visible one cycle later.
// Backpressure: writes while full without a same-cycle read are dropped and reported on wr_drop.
module bf16_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         wr_vld,
    input  logic [WIDTH-1:0]             wr_dat,
    output logic                         wr_drop,
    output logic                         rd_vld,
    input  logic                         rd_rdy,
    output logic [WIDTH-1:0]             rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             full;
    logic             rd_fire;
    logic             wr_ok;

    assign full    = (count == LW'(DEPTH));
    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld & rd_rdy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok   = wr_vld & (!full | rd_fire);
    assign wr_drop = wr_vld & full & !rd_fire;
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
    assign level   = count;

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_fire})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bf16_round_pack.sv
// Rounds fp32 adder results to bfloat16 (RNE), flags specials; result reaches out_valid two cycles after in_valid.
// Backpressure: input never stalls; results arriving at a full FIFO are dropped and set sticky overrun.
module bf16_round_pack #(
    parameter int DEPTH = 4,
    parameter bit FTZ   = 1'b1
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         in_valid,
    input  logic [31:0]                  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic [3:0]                   out_flags,
    output logic                         overrun,
    input  logic                         clear_overrun,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    import bf16_pkg::*;

    logic [FP32_EXP_W-1:0] exp_f;
    logic [FP32_MAN_W-1:0] man_f;
    logic                  round_up;
    logic [15:0]           rounded;
    logic [15:0]           r_dat;
    bf16_flags_t           r_flags;

    logic                  s1_vld;
    logic [15:0]           s1_dat;
    bf16_flags_t           s1_flags;
    logic                  drop;
    logic [19:0]           fifo_dat;

    assign exp_f = in_data[FP32_MAN_W +: FP32_EXP_W];
    assign man_f = in_data[FP32_MAN_W-1:0];

    always_comb begin
        round_up = in_data[15] & ((|in_data[14:0]) | in_data[16]);
        rounded  = in_data[31:16] + {15'b0, round_up};
        r_dat    = '0;
        r_flags  = '0;
        if (exp_f == EXP_MAX) begin
            if (man_f != '0) begin
                r_dat       = BF16_QNAN;
                r_flags.nan = 1'b1;
            end else begin
                r_dat = {in_data[31], BF16_POS_INF[14:0]};
            end
        end else if (FTZ && exp_f == '0) begin
            r_dat           = {in_data[31], 15'b0};
            r_flags.zero    = 1'b1;
            r_flags.inexact = (man_f != '0);
        end else begin
            // Mantissa carry runs into the exponent; reaching the all-ones exponent means infinity.
            r_dat            = rounded;
            r_flags.inexact  = |in_data[15:0];
            r_flags.overflow = (rounded[BF16_MAN_W +: BF16_EXP_W] == EXP_MAX);
            r_flags.zero     = (rounded[14:0] == '0);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
            s1_flags <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat   <= r_dat;
                s1_flags <= r_flags;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    bf16_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (20)
    ) u_fifo (
        .clock   (clock),
        .nreset  (nreset),
        .wr_vld  (s1_vld),
        .wr_dat  ({s1_flags, s1_dat}),
        .wr_drop (drop),
        .rd_vld  (out_valid),
        .rd_rdy  (out_ready),
        .rd_dat  (fifo_dat),
        .level   (level)
    );

    assign out_data  = fifo_dat[15:0];
    assign out_flags = fifo_dat[19:16];

endmodule

// File: tb/tb_bf16_round_pack.sv
// Bench for bf16_round_pack: directed corner cases, FIFO backpressure/overrun, async reset,
// and random vectors against a value-level RNE model on FTZ=1 and FTZ=0 instances.
module tb_bf16_round_pack;

    logic        clock = 1'b0;
    logic        nreset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        out_ready_nf;
    logic        clear_overrun;

    logic        out_valid,   out_valid_nf;
    logic [15:0] out_data,    out_data_nf;
    logic [3:0]  out_flags,   out_flags_nf;
    logic        overrun,     overrun_nf;
    logic [2:0]  level,       level_nf;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    bf16_round_pack #(.DEPTH(4), .FTZ(1'b1)) dut (
        .clock         (clock),
        .nreset        (nreset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_flags     (out_flags),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .level         (level)
    );

    bf16_round_pack #(.DEPTH(4), .FTZ(1'b0)) dut_nf (
        .clock         (clock),
        .nreset        (nreset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid_nf),
        .out_ready     (out_ready_nf),
        .out_data      (out_data_nf),
        .out_flags     (out_flags_nf),
        .overrun       (overrun_nf),
        .clear_overrun (clear_overrun),
        .level         (level_nf)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {nan, overflow, inexact, zero, bf16} from the value-level rounding rules.
    function automatic logic [19:0] model(input logic [31:0] x, input bit ftz);
        logic [7:0]  e;
        logic [22:0] m;
        int unsigned u;
        int unsigned rem;
        logic [15:0] r;
        logic        ov;
        logic        inx;
        logic        zr;
        e = x[30:23];
        m = x[22:0];
        if (e == 8'd255) begin
            if (m != 0) return {4'b1000, 16'h7FC0};
            return {4'b0000, x[31], 15'h7F80};
        end
        if (e == 8'd0 && ftz) return {2'b00, (m != 0), 1'b1, x[31], 15'h0};
        u   = x[31:16];
        rem = x[15:0];
        if (rem > 32'd32768 || (rem == 32'd32768 && (u % 2) == 1)) u = u + 1;
        r   = u[15:0];
        inx = (rem != 0);
        ov  = ((r & 16'h7FFF) == 16'h7F80);
        zr  = ((r & 16'h7FFF) == 16'h0000);
        return {1'b0, ov, inx, zr, r};
    endfunction

    // One isolated result through both instances; both heads must be ready to pop.
    task automatic send(input string tag, input logic [31:0] x,
                        input logic [15:0] d1, input logic [3:0] f1,
                        input logic [15:0] d0, input logic [3:0] f0);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        check({tag, "/early"}, out_valid, 0);
        tick();
        check({tag, "/vld"},     out_valid,    1);
        check({tag, "/dat"},     out_data,     d1);
        check({tag, "/flg"},     out_flags,    f1);
        check({tag, "/dat_nf"},  out_data_nf,  d0);
        check({tag, "/flg_nf"},  out_flags_nf, f0);
    endtask

    initial begin
        logic [31:0] x;
        logic [19:0] e1;
        logic [19:0] e0;

        nreset        = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        out_ready_nf  = 1'b1;
        clear_overrun = 1'b0;
        #12;
        check("rst/vld",   out_valid, 0);
        check("rst/dat",   out_data,  0);
        check("rst/flg",   out_flags, 0);
        check("rst/ovr",   overrun,   0);
        check("rst/level", level,     0);
        @(negedge clock);
        nreset = 1'b1;
        tick();

        out_ready = 1'b1;
        send("tie_even", 32'h3F808000, 16'h3F80, 4'b0010, 16'h3F80, 4'b0010);
        send("tie_odd",  32'h3F818000, 16'h3F82, 4'b0010, 16'h3F82, 4'b0010);
        send("sticky",   32'h3F808001, 16'h3F81, 4'b0010, 16'h3F81, 4'b0010);
        send("exact",    32'h40490000, 16'h4049, 4'b0000, 16'h4049, 4'b0000);
        send("ovf",      32'h7F7FFFFF, 16'h7F80, 4'b0110, 16'h7F80, 4'b0110);
        send("nan",      32'hFFFFFFFF, 16'h7FC0, 4'b1000, 16'h7FC0, 4'b1000);
        send("ninf",     32'hFF800000, 16'hFF80, 4'b0000, 16'hFF80, 4'b0000);
        send("nsub",     32'h80001234, 16'h8000, 4'b0011, 16'h8000, 4'b0011);
        send("sub_up",   32'h007FFFFF, 16'h0000, 4'b0011, 16'h0080, 4'b0010);
        send("pzero",    32'h00000000, 16'h0000, 4'b0001, 16'h0000, 4'b0001);
        send("nsub_max", 32'h80FF8000, 16'h8100, 4'b0010, 16'h8100, 4'b0010);
        tick();
        check("idle/level", level, 0);

        // Backpressure: five results into a four-deep FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h3F800000 + (k << 16);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("bp/level", level,   4);
        check("bp/ovr",   overrun, 1);
        check("bp/hold",  out_data, 16'h3F81);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("bp/pop%0d_vld", k), out_valid, 1);
            check($sformatf("bp/pop%0d", k),     out_data,  16'h3F80 + k);
            tick();
        end
        check("bp/empty_vld", out_valid, 0);
        check("bp/empty_lvl", level,     0);
        check("bp/ovr_sticky", overrun,  1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("bp/ovr_clr", overrun, 0);

        // Full FIFO with a push and a pop in the same cycle.
        out_ready = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h3F800000 + (k << 16);
            tick();
            if (k == 9) begin
                in_valid = 1'b0;
                tick();
                tick();
                check("pp/full", level, 4);
            end
        end
        out_ready = 1'b1;
        in_data   = 32'h3F800000 + (11 << 16);
        check("pp/head6", out_data, 16'h3F86);
        tick();
        check("pp/level_a", level, 4);
        in_data = 32'h3F800000 + (12 << 16);
        check("pp/head7", out_data, 16'h3F87);
        tick();
        in_valid = 1'b0;
        check("pp/level_b", level, 4);
        for (int k = 8; k <= 12; k++) begin
            check($sformatf("pp/pop%0d_vld", k), out_valid, 1);
            check($sformatf("pp/pop%0d", k),     out_data,  16'h3F80 + k);
            tick();
        end
        check("pp/ovr",   overrun, 0);
        check("pp/level", level,   0);

        // Asynchronous reset with entries queued.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h40000000 + (k << 16);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("ar/level_pre", level, 3);
        #2;
        nreset = 1'b0;
        #1;
        check("ar/vld",   out_valid, 0);
        check("ar/level", level,     0);
        #2;
        nreset = 1'b1;
        tick();
        out_ready = 1'b1;
        send("ar/first", 32'h40490000, 16'h4049, 4'b0000, 16'h4049, 4'b0000);

        // Random vectors, biased toward exponent and rounding corners.
        for (int n = 0; n < 200; n++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0: x[30:23] = 8'h00;
                1: x[30:23] = 8'hFF;
                2: x[30:23] = 8'hFE;
                3: x[15:0]  = 16'h8000;
                4: x[14:0]  = 15'h0;
                default: ;
            endcase
            e1 = model(x, 1'b1);
            e0 = model(x, 1'b0);
            send($sformatf("rnd%0d_%h", n, x), x, e1[15:0], e1[19:16], e0[15:0], e0[19:16]);
        end
        tick();
        check("end/level",    level,    0);
        check("end/level_nf", level_nf, 0);
        check("end/ovr_nf",   overrun_nf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bf16_round_pack.md
Name: bf16_round_pack

Overview:
- Downstream of the fp32 adder core; consumes its 32-bit result and the one-cycle completion pulse.
- Rounds the result to bfloat16 with round-to-nearest-even, replacing the current plain truncation of sum[31:16].
- Canonicalises special values and raises status flags.
- Buffers results in a small FIFO with valid/ready output, because the adder cannot be stalled.

Parameters:
- DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- FTZ, 1, 1 = flush subnormal results to signed zero; 0 = round subnormals like normals.

Ports:
- clock  in  1  clock
- nreset  in  1  reset; asynchronous, active-low
- in_valid  in  1  one-cycle pulse; in_data is valid in that cycle
- in_data  in  32  fp32 result (sign, 8-bit exponent, 23-bit mantissa)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  16  rounded bfloat16
- out_flags  out  4  {nan, overflow, inexact, zero}; aligned with out_data
- overrun  out  1  sticky; a result was dropped
- clear_overrun  in  1  synchronous clear of overrun
- level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, nreset low): out_valid=0, out_data=0, out_flags=0, overrun=0, level=0. The stage-1 register, FIFO pointers and count are cleared. In-flight results are discarded, with no flag set.
- Pipeline:
  - In_valid in cycle N: stage-1 register loads the rounded word and flags at the end of N.
  - FIFO write at the end of N+1.
  - out_valid is high in N+2 at the earliest.
  - Stage 1 never stalls; there is no input ready.
- Rounding (ordinary finite inputs):
  - U = in_data[31:16]; G = in_data[15]; RS = OR of in_data[14:0].
  - Round up iff G & (RS | U[0]); result = U + 1 as a 16-bit add.
  - A mantissa carry propagates into the exponent.
  - inexact = OR of in_data[15:0].
- Overflow: a finite input with exponent 0xFE that rounds up to 0x7F80/0xFF80 gives signed infinity; overflow=1, inexact=1.
- NaN (exponent 0xFF, mantissa nonzero, including the adder's all-ones 0xFFFFFFFF): out_data=16'h7FC0, nan=1, all other flags 0.
- Infinity (exponent 0xFF, mantissa 0): passes {sign, 0x7F80}; no flags.
- Zero or subnormal input (exponent 0x00):
  - FTZ=1: out={sign,15'b0}, zero=1; inexact=1 iff mantissa nonzero.
  - FTZ=0: apply the rounding rule above; zero=1 iff the result magnitude is 0.
- A rounded result of magnitude 0 always sets zero=1.
- FIFO:
  - Pop when out_valid & out_ready; push when the stage-1 register is valid.
  - Push while full without a same-cycle pop: the new entry is dropped, FIFO contents are unchanged, overrun is set.
  - Push and pop in the same cycle while full: both occur, no overrun, level unchanged.
  - Push and pop in the same cycle while empty: the entry is written; there is no bypass, so out_valid rises the next cycle.
  - Pointers wrap modulo DEPTH. level is exact at all times.
  - out_data and out_flags hold their values while out_valid & !out_ready.
- clear_overrun in the same cycle as a new drop: set wins (overrun stays 1).

Decomposition:
- Shared package bf16_pkg:
  - BF16_QNAN = 16'h7FC0 and BF16_POS_INF = 16'h7F80.
  - Exponent and mantissa width constants (8/23 for fp32, 8/7 for bf16).
  - Flag bit indices, or a packed struct type bf16_flags_t for {nan, overflow, inexact, zero}.
- One sub-module: bf16_out_fifo.
  - Parameterised by DEPTH and payload width (20 bits: data plus flags).
  - Holds the pointers, count and full/empty logic.
- Rounding and classification stay in bf16_round_pack as combinational logic feeding the stage-1 register.

Test Plan:
- Tie: in_data=0x3F808000 -> out 0x3F80, flags 0010 (inexact). in_data=0x3F818000 -> out 0x3F82, flags 0010.
- Sticky rounding: in_data=0x3F808001 -> out 0x3F81, inexact. Exact input 0x40490000 -> out 0x4049, flags 0000.
- Overflow: 0x7F7FFFFF -> out 0x7F80, flags 0110.
- Specials:
  - 0xFFFFFFFF -> 0x7FC0, flags 1000.
  - 0xFF800000 -> 0xFF80, flags 0000.
  - FTZ=1, 0x80001234 -> 0x8000, flags 0011.
- Backpressure: out_ready=0, five in_valid pulses with values 1..5 (e.g. 0x3F800000 + k<<16).
  - level reaches 4, overrun=1, the fifth value is lost.
  - Then out_ready=1: values 1..4 are popped in order, level returns to 0.
  - clear_overrun pulse -> overrun=0.
- Full with simultaneous push and pop: no overrun, level stays 4, ordering preserved.
- Reset mid-stream: nreset asserted with 3 entries queued -> out_valid=0 and level=0 immediately (asynchronous). After release, the first new input appears in cycle N+2.
